ifft4_seq: RTL and testbench

IFFT4_SEQ -- requirements
Module: ifft4_seq

---
 rtl/fft_pkg.sv | 30 +++
 rtl/ifft4_seq_if.sv | 22 ++
 rtl/ifft4_half_bfly.sv | 26 ++
 rtl/ifft4_seq.sv | 162 ++++++++++++++++
 tb/tb_ifft4_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point sequential inverse FFT.
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 32;
  localparam int unsigned FFT_HALF  = FFT_WIDTH / 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STAGE1 = 2'd1,
    STAGE2 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Pack real/imag halves into one complex word (real in the upper half).
  function automatic logic [FFT_WIDTH-1:0] cpack(input logic signed [FFT_HALF-1:0] re,
                                                 input logic signed [FFT_HALF-1:0] im);
    return {re, im};
  endfunction

  // Real half of a packed complex word.
  function automatic logic signed [FFT_HALF-1:0] cre(input logic [FFT_WIDTH-1:0] s);
    return s[FFT_WIDTH-1:FFT_HALF];
  endfunction

  // Imaginary half of a packed complex word.
  function automatic logic signed [FFT_HALF-1:0] cim(input logic [FFT_WIDTH-1:0] s);
    return s[FFT_HALF-1:0];
  endfunction

endpackage

// File: rtl/ifft4_seq_if.sv
// Sample-in / sample-out valid-ready bus of the 4-point inverse FFT.
interface ifft4_seq_if #(
  parameter int unsigned WIDTH = fft_pkg::FFT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ifft4_half_bfly.sv
// One real-valued radix-2 butterfly: (a+b)/2 and (a-b)/2 with floor rounding.
module ifft4_half_bfly #(
  parameter int unsigned HALF = 16
) (
  input  logic signed [HALF-1:0] a,
  input  logic signed [HALF-1:0] b,
  output logic signed [HALF-1:0] sum_c,
  output logic signed [HALF-1:0] dif_c
);
  localparam int unsigned EXT = HALF + 1;

  logic [EXT-1:0] sum_w;
  logic [EXT-1:0] dif_w;
  logic           unused_lsb;

  // Sign-extend by one bit so the sum/difference cannot wrap, then drop the LSB (floor /2).
  always_comb begin
    sum_w = {a[HALF-1], a} + {b[HALF-1], b};
    dif_w = {a[HALF-1], a} - {b[HALF-1], b};
    sum_c = sum_w[EXT-1:1];
    dif_c = dif_w[EXT-1:1];
  end

  assign unused_lsb = sum_w[0] ^ dif_w[0];

endmodule

// File: rtl/ifft4_seq.sv
// Sequential 4-point inverse DFT: load 4 samples, two radix-2 stages, drain 4 samples.
module ifft4_seq
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  ifft4_seq_if.slave  bus,
  output logic        busy
);
  localparam int unsigned HALF = WIDTH / 2;

  state_t state_q, state_n;
  logic [1:0]       cnt_q, cnt_n;
  logic [1:0]       oidx_q, oidx_n;
  logic [WIDTH-1:0] xin_q [4];
  logic [WIDTH-1:0] xin_n [4];
  logic [WIDTH-1:0] a_q   [4];
  logic [WIDTH-1:0] a_n   [4];
  logic [WIDTH-1:0] y_q   [4];
  logic [WIDTH-1:0] y_n   [4];
  logic [WIDTH-1:0] out_data_q, out_data_n;
  logic             in_ready_q, in_ready_n;
  logic             out_valid_q, out_valid_n;
  logic             out_last_q, out_last_n;
  logic             busy_q, busy_n;

  logic signed [HALF-1:0] xr [4];
  logic signed [HALF-1:0] xi [4];
  logic signed [HALF-1:0] ar [4];
  logic signed [HALF-1:0] ai [4];

  logic signed [HALF-1:0] s1_a0r, s1_a1r, s1_a0i, s1_a1i;
  logic signed [HALF-1:0] s1_a2r, s1_a3i, s1_a2i, s1_a3r;
  logic signed [HALF-1:0] s2_x0r, s2_x2r, s2_x0i, s2_x2i;
  logic signed [HALF-1:0] s2_x1r, s2_x3r, s2_x1i, s2_x3i;

  // Split stored samples and stage-1 results into real/imag halves.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr[k] = xin_q[k][WIDTH-1:HALF];
      xi[k] = xin_q[k][HALF-1:0];
      ar[k] = a_q[k][WIDTH-1:HALF];
      ai[k] = a_q[k][HALF-1:0];
    end
  end

  // Stage 1: a0/a1 from X0,X2; a2 and j*(X1-X3) from X1,X3 (operand swap folds the negation in).
  ifft4_half_bfly #(.HALF(HALF)) u_s1_02r (.a(xr[0]), .b(xr[2]), .sum_c(s1_a0r), .dif_c(s1_a1r));
  ifft4_half_bfly #(.HALF(HALF)) u_s1_02i (.a(xi[0]), .b(xi[2]), .sum_c(s1_a0i), .dif_c(s1_a1i));
  ifft4_half_bfly #(.HALF(HALF)) u_s1_13r (.a(xr[1]), .b(xr[3]), .sum_c(s1_a2r), .dif_c(s1_a3i));
  ifft4_half_bfly #(.HALF(HALF)) u_s1_31i (.a(xi[3]), .b(xi[1]), .sum_c(s1_a2i), .dif_c(s1_a3r));

  // Stage 2: x0/x2 from a0,a2; x1/x3 from a1,a3.
  ifft4_half_bfly #(.HALF(HALF)) u_s2_02r (.a(ar[0]), .b(ar[2]), .sum_c(s2_x0r), .dif_c(s2_x2r));
  ifft4_half_bfly #(.HALF(HALF)) u_s2_02i (.a(ai[0]), .b(ai[2]), .sum_c(s2_x0i), .dif_c(s2_x2i));
  ifft4_half_bfly #(.HALF(HALF)) u_s2_13r (.a(ar[1]), .b(ar[3]), .sum_c(s2_x1r), .dif_c(s2_x3r));
  ifft4_half_bfly #(.HALF(HALF)) u_s2_13i (.a(ai[1]), .b(ai[3]), .sum_c(s2_x1i), .dif_c(s2_x3i));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    oidx_n     = oidx_q;
    xin_n      = xin_q;
    a_n        = a_q;
    y_n        = y_q;
    out_data_n = out_data_q;

    case (state_q)
      LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          xin_n[cnt_q] = bus.in_data;
          cnt_n        = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_n = STAGE1;
          end
        end
      end
      STAGE1: begin
        a_n[0]  = {s1_a0r, s1_a0i};
        a_n[1]  = {s1_a1r, s1_a1i};
        a_n[2]  = {s1_a2r, s1_a2i};
        a_n[3]  = {s1_a3r, s1_a3i};
        state_n = STAGE2;
      end
      STAGE2: begin
        y_n[0]     = {s2_x0r, s2_x0i};
        y_n[1]     = {s2_x1r, s2_x1i};
        y_n[2]     = {s2_x2r, s2_x2i};
        y_n[3]     = {s2_x3r, s2_x3i};
        out_data_n = {s2_x0r, s2_x0i};
        oidx_n     = 2'd0;
        state_n    = DRAIN;
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (oidx_q == 2'd3) begin
            oidx_n     = 2'd0;
            cnt_n      = 2'd0;
            out_data_n = '0;
            state_n    = LOAD;
          end else begin
            oidx_n     = 2'(oidx_q + 2'd1);
            out_data_n = y_q[2'(oidx_q + 2'd1)];
          end
        end
      end
      default: begin
        state_n = LOAD;
        cnt_n   = 2'd0;
        oidx_n  = 2'd0;
      end
    endcase

    in_ready_n  = (state_n == LOAD);
    out_valid_n = (state_n == DRAIN);
    out_last_n  = (state_n == DRAIN) && (oidx_n == 2'd3);
    busy_n      = !((state_n == LOAD) && (cnt_n == 2'd0));
  end

  // State, sample/stage storage and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= 2'd0;
      oidx_q      <= 2'd0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        xin_q[k] <= '0;
        a_q[k]   <= '0;
        y_q[k]   <= '0;
      end
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      oidx_q      <= oidx_n;
      out_data_q  <= out_data_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_last_q  <= out_last_n;
      busy_q      <= busy_n;
      for (int k = 0; k < 4; k++) begin
        xin_q[k] <= xin_n[k];
        a_q[k]   <= a_n[k];
        y_q[k]   <= y_n[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ifft4_seq.sv
// Scoreboard bench for ifft4_seq: known vectors, random frames, backpressure and mid-frame reset.
module tb_ifft4_seq;
  import fft_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  ifft4_seq_if #(.WIDTH(W)) bus ();

  ifft4_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q [$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] c(input int re, input int im);
    return cpack(16'(re), 16'(im));
  endfunction

  // Reference inverse DFT built from the radix-2 equations with floor halving per stage.
  task automatic model(input logic [W-1:0] xs [4], output logic [W-1:0] ys [4]);
    int xr [4], xi [4], ar [4], ai [4], yr [4], yi [4];
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'(cre(xs[k]));
      xi[k] = int'(cim(xs[k]));
    end
    ar[0] = (xr[0] + xr[2]) >>> 1;  ai[0] = (xi[0] + xi[2]) >>> 1;
    ar[1] = (xr[0] - xr[2]) >>> 1;  ai[1] = (xi[0] - xi[2]) >>> 1;
    ar[2] = (xr[1] + xr[3]) >>> 1;  ai[2] = (xi[1] + xi[3]) >>> 1;
    ar[3] = (xi[3] - xi[1]) >>> 1;  ai[3] = (xr[1] - xr[3]) >>> 1;
    yr[0] = (ar[0] + ar[2]) >>> 1;  yi[0] = (ai[0] + ai[2]) >>> 1;
    yr[1] = (ar[1] + ar[3]) >>> 1;  yi[1] = (ai[1] + ai[3]) >>> 1;
    yr[2] = (ar[0] - ar[2]) >>> 1;  yi[2] = (ai[0] - ai[2]) >>> 1;
    yr[3] = (ar[1] - ar[3]) >>> 1;  yi[3] = (ai[1] - ai[3]) >>> 1;
    for (int n = 0; n < 4; n++) ys[n] = c(yr[n], yi[n]);
  endtask

  task automatic push_exp(input logic [W-1:0] ys [4]);
    for (int n = 0; n < 4; n++) exp_q.push_back({(n == 3), ys[n]});
  endtask

  // Drive four samples at negedges; optional one-cycle gap and junk traffic after the frame.
  task automatic send_frame(input logic [W-1:0] xs [4], input bit junk, input bit gap);
    int waited;
    for (int k = 0; k < 4; k++) begin
      if (gap && k == 2) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = xs[k];
      waited = 0;
      while (!bus.in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.in_ready) check("in_ready_timeout", W'(bus.in_ready), W'(1));
      @(negedge clk);
    end
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hdead_beef;
    end else begin
      bus.in_valid = 1'b0;
    end
    check("in_ready_after_x3", W'(bus.in_ready), W'(0));
    check("busy_after_x3", W'(busy), W'(1));
  endtask

  // Collect n outputs against the scoreboard; optionally stall one of them.
  task automatic recv(input int n, input bit chk_lat, input int stall_at, input int stall_len);
    int waits;
    logic [W:0] e;
    logic [W-1:0] hold;
    for (int i = 0; i < n; i++) begin
      waits = 0;
      while (!bus.out_valid && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      if (i == 0 && chk_lat) check("latency", W'(waits), W'(2));
      else if (i > 0) check($sformatf("bubble_x%0d", i), W'(waits), W'(0));
      check("busy_drain", W'(busy), W'(1));
      if (i == stall_at) begin
        hold = bus.out_data;
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_data", bus.out_data, hold);
          check("stall_valid", W'(bus.out_valid), W'(1));
          check("stall_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
      end
      if (i == 3) bus.in_valid = 1'b0;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", W'(1), W'(0));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("x%0d_data", i), bus.out_data, e[W-1:0]);
        check($sformatf("x%0d_last", i), W'(bus.out_last), W'(e[W]));
      end
      @(negedge clk);
    end
    if (n == 4) begin
      check("idle_out_valid", W'(bus.out_valid), W'(0));
      check("idle_in_ready", W'(bus.in_ready), W'(1));
      check("idle_busy", W'(busy), W'(0));
    end
  endtask

  task automatic run_const(input logic [W-1:0] xs [4], input logic [W-1:0] ys [4],
                           input int stall_at, input bit junk, input bit gap);
    push_exp(ys);
    send_frame(xs, junk, gap);
    recv(4, 1'b1, stall_at, 3);
  endtask

  initial begin
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_last", W'(bus.out_last), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse
    xs = '{c(4, 0), c(0, 0), c(0, 0), c(0, 0)};
    ys = '{c(1, 0), c(1, 0), c(1, 0), c(1, 0)};
    run_const(xs, ys, -1, 1'b0, 1'b0);

    // Single bin X1
    xs = '{c(0, 0), c(4, 0), c(0, 0), c(0, 0)};
    ys = '{c(1, 0), c(0, 1), c(-1, 0), c(0, -1)};
    run_const(xs, ys, -1, 1'b0, 1'b0);

    // Floor rounding of negative and positive odd values
    xs = '{c(-1, 0), c(0, 0), c(0, 0), c(0, 0)};
    ys = '{c(-1, 0), c(-1, 0), c(-1, 0), c(-1, 0)};
    run_const(xs, ys, -1, 1'b0, 1'b0);
    xs = '{c(1, 0), c(0, 0), c(0, 0), c(0, 0)};
    ys = '{c(0, 0), c(0, 0), c(0, 0), c(0, 0)};
    run_const(xs, ys, -1, 1'b0, 1'b0);

    // Full-scale negative inputs must not wrap
    xs = '{c(-32768, -32768), c(-32768, -32768), c(-32768, -32768), c(-32768, -32768)};
    ys = '{c(-32768, -32768), c(0, 0), c(0, 0), c(0, 0)};
    run_const(xs, ys, -1, 1'b0, 1'b0);

    // Backpressure on x1, with junk in_valid during processing and an input gap
    xs = '{c(0, 0), c(4, 0), c(0, 0), c(0, 0)};
    ys = '{c(1, 0), c(0, 1), c(-1, 0), c(0, -1)};
    run_const(xs, ys, 1, 1'b1, 1'b1);

    // Random frames against the reference model
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) xs[k] = $urandom();
      model(xs, ys);
      push_exp(ys);
      send_frame(xs, f[0], f[1]);
      recv(4, 1'b1, (f == 3) ? 2 : -1, 3);
    end

    // Reset in the middle of DRAIN after x0 has been accepted
    xs = '{c(4, 0), c(0, 0), c(0, 0), c(0, 0)};
    ys = '{c(1, 0), c(1, 0), c(1, 0), c(1, 0)};
    push_exp(ys);
    send_frame(xs, 1'b0, 1'b0);
    recv(1, 1'b1, -1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_in_ready", W'(bus.in_ready), W'(1));
    check("midrst_out_last", W'(bus.out_last), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_out_data", bus.out_data, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_out_valid", W'(bus.out_valid), W'(0));
    run_const(xs, ys, -1, 1'b0, 1'b0);

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
